// File: rtl/tartaruga_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and transaction owner.
package tartaruga_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } mem_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_arbiter.
// master = arbiter view, slave = memory/requester view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        flush;
    logic        error;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  mem_gnt, mem_rvalid, mem_rdata, flush,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be, error
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output mem_gnt, mem_rvalid, mem_rdata, flush,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, error
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN: contention goes to the requester not granted last; otherwise DM wins.
module mem_arb_pick
    import tartaruga_pkg::*;
(
    input  logic       if_req_i,
    input  logic       dm_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  mem_owner_t last_owner_i,
`endif
    output logic       any_req_o,
    output mem_owner_t winner_o
);

    always_comb begin
        any_req_o = if_req_i | dm_req_i;
        winner_o  = OWNER_DM;
        if (if_req_i && !dm_req_i) begin
            winner_o = OWNER_IF;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        else if (if_req_i && dm_req_i && (last_owner_i == OWNER_DM)) begin
            winner_o = OWNER_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-outstanding memory port with timeout.
// Optional macro MEM_ARB_ROUND_ROBIN_EN switches contention from DM-priority to round robin.
module mem_arbiter
    import tartaruga_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [3:0]  dm_be_i,
    output logic        dm_gnt_o,
    output logic        dm_rvalid_o,
    output logic [31:0] dm_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    input  logic        flush_i,
    output logic        error_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_arb_state_t   state_q, state_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    mem_owner_t       last_q, last_d;
`endif

    logic       fetch_live;
    logic       any_req;
    mem_owner_t winner;

    // A fetch raised while the pipeline is being redirected is stale.
    assign fetch_live = if_req_i & ~flush_i;

    mem_arb_pick u_pick (
        .if_req_i     (fetch_live),
        .dm_req_i     (dm_req_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner_i (last_q),
`endif
        .any_req_o    (any_req),
        .winner_o     (winner)
    );

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        error_d = error_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_gnt_o    = 1'b0;
        dm_rvalid_o = 1'b0;
        dm_rdata_o  = '0;

        // Outputs are held quiet while reset is asserted, even with requests pending.
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        mem_req_o = 1'b1;
                        if (winner == OWNER_IF) begin
                            mem_addr_o = if_addr_i;
                            mem_be_o   = 4'hF;
                        end else begin
                            mem_we_o    = dm_we_i;
                            mem_addr_o  = dm_addr_i;
                            mem_wdata_o = dm_wdata_i;
                            mem_be_o    = dm_be_i;
                        end
                        if (mem_gnt_i) begin
                            cnt_d  = '0;
                            drop_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            last_d = winner;
`endif
                            if (winner == OWNER_IF) begin
                                if_gnt_o = 1'b1;
                                state_d  = WAIT_IF;
                            end else begin
                                dm_gnt_o = 1'b1;
                                state_d  = WAIT_DM;
                            end
                        end
                    end
                end
                WAIT_IF, WAIT_DM: begin
                    if (mem_rvalid_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        drop_d  = 1'b0;
                        if (state_q == WAIT_IF) begin
                            if_rvalid_o = ~(drop_q | flush_i);
                            if_rdata_o  = mem_rdata_i;
                        end else begin
                            dm_rvalid_o = 1'b1;
                            dm_rdata_o  = mem_rdata_i;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        drop_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if ((state_q == WAIT_IF) && flush_i) begin
                            drop_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
            error_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= OWNER_DM;
`endif
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign error_o = error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: IDLE vector table, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    import tartaruga_pkg::*;

    localparam int TIMEOUT = 16;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .if_req_i     (bus.if_req),
        .if_addr_i    (bus.if_addr),
        .if_gnt_o     (bus.if_gnt),
        .if_rvalid_o  (bus.if_rvalid),
        .if_rdata_o   (bus.if_rdata),
        .dm_req_i     (bus.dm_req),
        .dm_we_i      (bus.dm_we),
        .dm_addr_i    (bus.dm_addr),
        .dm_wdata_i   (bus.dm_wdata),
        .dm_be_i      (bus.dm_be),
        .dm_gnt_o     (bus.dm_gnt),
        .dm_rvalid_o  (bus.dm_rvalid),
        .dm_rdata_o   (bus.dm_rdata),
        .mem_req_o    (bus.mem_req),
        .mem_we_o     (bus.mem_we),
        .mem_addr_o   (bus.mem_addr),
        .mem_wdata_o  (bus.mem_wdata),
        .mem_be_o     (bus.mem_be),
        .mem_gnt_i    (bus.mem_gnt),
        .mem_rvalid_i (bus.mem_rvalid),
        .mem_rdata_i  (bus.mem_rdata),
        .flush_i      (bus.flush),
        .error_o      (bus.error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.flush = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    function automatic logic [6:0] ctl_outs();
        return {bus.mem_req, bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.error, bus.mem_we};
    endfunction

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_be;
        logic        flush;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t tbl[7];

    // reference model state
    bit m_busy, m_own_if, m_drop, m_err, m_last_if;
    int m_waited;
    bit g_if, g_dm;

    initial begin
        logic        e_req, e_we, e_ig, e_dg, e_irv, e_drv, e_err, fl, pick_if;
        logic [31:0] e_addr, e_wdata, e_ird, e_drd, a_ird, a_drd;
        logic [3:0]  e_be;

        clear_inputs();
        rst = 1;
        @(negedge clk);
        // requests present during reset must not leak to the outputs
        bus.if_req = 1; bus.dm_req = 1; bus.mem_gnt = 1; bus.mem_rvalid = 1;
        #1 check("reset outputs", 160'(ctl_outs()), 160'(0));
        cyc();
        #1 check("reset outputs 2", 160'(ctl_outs()), 160'(0));
        clear_inputs();
        rst = 0;
        #1 check("post reset idle", 160'({ctl_outs(), bus.mem_addr}), 160'(0));

        // ---- IDLE combinational vectors (no grant, state stays IDLE) ----
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0, 4'hF};
        tbl[2] = '{0, 0, 1, 1, 32'h80, 32'h12345678, 4'h3, 0, 1, 1, 32'h80, 32'h12345678, 4'h3};
        tbl[3] = '{0, 0, 1, 0, 32'h84, 32'hAAAA, 4'hC, 0, 1, 0, 32'h84, 32'hAAAA, 4'hC};
        tbl[4] = '{1, 32'h44, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 32'h48, 1, 1, 32'h88, 32'h5, 4'h1, 1, 1, 1, 32'h88, 32'h5, 4'h1};
        if (RR) tbl[6] = '{1, 32'h4C, 1, 1, 32'h8C, 32'h6, 4'h2, 0, 1, 0, 32'h4C, 0, 4'hF};
        else    tbl[6] = '{1, 32'h4C, 1, 1, 32'h8C, 32'h6, 4'h2, 0, 1, 1, 32'h8C, 32'h6, 4'h2};
        for (int i = 0; i < 7; i++) begin
            bus.if_req = tbl[i].if_req;   bus.if_addr = tbl[i].if_addr;
            bus.dm_req = tbl[i].dm_req;   bus.dm_we = tbl[i].dm_we;
            bus.dm_addr = tbl[i].dm_addr; bus.dm_wdata = tbl[i].dm_wdata;
            bus.dm_be = tbl[i].dm_be;     bus.flush = tbl[i].flush;
            #1 check($sformatf("vector %0d", i),
                     160'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_gnt, bus.dm_gnt}),
                     160'({tbl[i].exp_req, tbl[i].exp_we, tbl[i].exp_addr, tbl[i].exp_wdata, tbl[i].exp_be, 2'b00}));
            cyc();
        end
        clear_inputs();

        // ---- single fetch, response 3 cycles after grant ----
        bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_gnt = 1;
        #1 check("fetch grant", 160'({bus.if_gnt, bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_we}),
                 160'({1'b1, 1'b1, 32'h100, 4'hF, 1'b0}));
        cyc(); bus.if_req = 0; bus.mem_gnt = 0;
        #1 check("fetch gnt one cycle", 160'({bus.if_gnt, bus.mem_req}), 160'(0));
        cyc();
        cyc(); bus.mem_rvalid = 1; bus.mem_rdata = 32'h13;
        #1 check("fetch rvalid", 160'({bus.if_rvalid, bus.if_rdata}), 160'({1'b1, 32'h13}));
        cyc(); bus.mem_rvalid = 0;
        #1 check("fetch rvalid one cycle", 160'(bus.if_rvalid), 160'(0));

        // ---- contention: store wins, fetch follows after store completes ----
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h1000; bus.dm_wdata = 32'hDEADBEEF; bus.dm_be = 4'hF;
        bus.mem_gnt = 1;
        #1 check("store wins", 160'({bus.dm_gnt, bus.if_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                 160'({1'b1, 1'b0, 1'b1, 32'h1000, 32'hDEADBEEF}));
        cyc(); bus.dm_req = 0;
        #1 check("fetch blocked in WAIT_DM", 160'({bus.if_gnt, bus.mem_req}), 160'(0));
        cyc(); bus.mem_rvalid = 1;
        #1 check("store done", 160'({bus.dm_rvalid, bus.if_gnt, bus.mem_req}), 160'({1'b1, 2'b00}));
        cyc(); bus.mem_rvalid = 0;
        #1 check("fetch granted after store", 160'({bus.if_gnt, bus.mem_addr}), 160'({1'b1, 32'h200}));
        cyc(); bus.if_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
        #1 check("fetch after store data", 160'({bus.if_rvalid, bus.if_rdata}), 160'({1'b1, 32'h77}));
        cyc(); bus.mem_rvalid = 0;

        // ---- flush kills in-flight fetch ----
        bus.if_req = 1; bus.if_addr = 32'h300; bus.mem_gnt = 1;
        #1 check("flush case grant", 160'(bus.if_gnt), 160'(1));
        cyc(); bus.if_req = 0; bus.mem_gnt = 0; bus.flush = 1;
        cyc(); bus.flush = 0;
        cyc(); bus.mem_rvalid = 1; bus.mem_rdata = 32'hFFFFFFFF;
        #1 check("flushed response dropped", 160'(bus.if_rvalid), 160'(0));
        cyc(); bus.mem_rvalid = 0;
        bus.if_req = 1; bus.if_addr = 32'h304; bus.mem_gnt = 1;
        #1 check("fetch after flush grant", 160'({bus.if_gnt, bus.mem_addr}), 160'({1'b1, 32'h304}));
        cyc(); bus.if_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
        #1 check("fetch after flush data", 160'({bus.if_rvalid, bus.if_rdata}), 160'({1'b1, 32'h55}));
        cyc(); bus.mem_rvalid = 0;

        // ---- load timeout ----
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000; bus.dm_be = 4'hF; bus.mem_gnt = 1;
        #1 check("load grant", 160'(bus.dm_gnt), 160'(1));
        cyc(); bus.dm_req = 0; bus.mem_gnt = 0;
        for (int k = 1; k < TIMEOUT; k++) cyc();
        #1 check("no error before timeout", 160'({bus.error, bus.mem_req}), 160'(0));
        cyc();
        #1 check("error after timeout", 160'({bus.error, bus.dm_rvalid}), 160'({1'b1, 1'b0}));
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h9;
        #1 check("late rvalid ignored in IDLE", 160'({bus.dm_rvalid, bus.if_rvalid}), 160'(0));
        cyc(); bus.mem_rvalid = 0;
        bus.if_req = 1; bus.if_addr = 32'h500; bus.mem_gnt = 1;
        #1 check("grant after timeout", 160'({bus.if_gnt, bus.error}), 160'({1'b1, 1'b1}));
        cyc(); bus.if_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1;
        cyc(); bus.mem_rvalid = 0;
        #1 check("error sticky", 160'(bus.error), 160'(1));

        // ---- reset in WAIT_DM ----
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h3000; bus.mem_gnt = 1;
        #1 check("pre-reset store grant", 160'(bus.dm_gnt), 160'(1));
        cyc(); bus.dm_req = 0; bus.mem_gnt = 0;
        rst = 1;
        cyc(); rst = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234;
        #1 check("rvalid after reset ignored", 160'({ctl_outs(), bus.dm_rdata}), 160'(0));
        cyc(); bus.mem_rvalid = 0;

        // ---- continuous contention ----
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h400; bus.dm_req = 1; bus.dm_addr = 32'h600; bus.mem_gnt = 1;
        for (int k = 0; k < 4; k++) begin
            logic exp_if;
            exp_if = RR && (k % 2 == 0);
            #1 check($sformatf("contention grant %0d", k), 160'({bus.if_gnt, bus.dm_gnt}), 160'({exp_if, !exp_if}));
            cyc(); bus.mem_rvalid = 1;
            cyc(); bus.mem_rvalid = 0;
        end

        // ---- randomized traffic vs reference model ----
        do_reset();
        m_busy = 0; m_own_if = 0; m_drop = 0; m_err = 0; m_last_if = 0; m_waited = 0;
        g_if = 0; g_dm = 0;
        for (int c = 0; c < 1500; c++) begin
            // requesters hold their request until it is granted
            if (!(bus.if_req && !g_if)) begin
                bus.if_req  = ($urandom_range(0, 2) == 0);
                bus.if_addr = $urandom;
            end
            if (!(bus.dm_req && !g_dm)) begin
                bus.dm_req   = ($urandom_range(0, 2) == 0);
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_addr  = $urandom;
                bus.dm_wdata = $urandom;
                bus.dm_be    = 4'($urandom_range(0, 15));
            end
            bus.flush      = ($urandom_range(0, 7) == 0);
            bus.mem_gnt    = 1'($urandom_range(0, 1));
            bus.mem_rvalid = ($urandom_range(0, 5) == 0);
            bus.mem_rdata  = $urandom;

            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_be = 0;
            e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_ird = 0; e_drd = 0;
            e_err = m_err;
            fl = bus.if_req && !bus.flush;
            if (!m_busy) begin
                if (fl || bus.dm_req) begin
                    if (fl && bus.dm_req) pick_if = RR && !m_last_if;
                    else                  pick_if = fl;
                    e_req = 1;
                    if (pick_if) begin
                        e_addr = bus.if_addr; e_be = 4'hF;
                    end else begin
                        e_we = bus.dm_we; e_addr = bus.dm_addr; e_wdata = bus.dm_wdata; e_be = bus.dm_be;
                    end
                    if (bus.mem_gnt) begin
                        e_ig = pick_if;
                        e_dg = !pick_if;
                    end
                end
            end else if (bus.mem_rvalid) begin
                if (m_own_if) begin
                    e_irv = !(m_drop || bus.flush);
                    if (e_irv) e_ird = bus.mem_rdata;
                end else begin
                    e_drv = 1;
                    e_drd = bus.mem_rdata;
                end
            end

            #1;
            a_ird = e_irv ? bus.if_rdata : 32'h0;
            a_drd = e_drv ? bus.dm_rdata : 32'h0;
            check($sformatf("random cycle %0d", c),
                  160'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.if_gnt, bus.dm_gnt,
                        bus.if_rvalid, bus.dm_rvalid, bus.error, a_ird, a_drd}),
                  160'({e_req, e_we, e_addr, e_wdata, e_be, e_ig, e_dg, e_irv, e_drv, e_err, e_ird, e_drd}));

            if (m_busy) begin
                m_waited++;
                if (bus.mem_rvalid) begin
                    m_busy = 0; m_drop = 0;
                end else if (m_waited == TIMEOUT) begin
                    m_busy = 0; m_drop = 0; m_err = 1;
                end else if (m_own_if && bus.flush) begin
                    m_drop = 1;
                end
            end else if (e_ig || e_dg) begin
                m_busy = 1; m_own_if = e_ig; m_waited = 0; m_drop = 0; m_last_if = e_ig;
            end
            g_if = e_ig;
            g_dm = e_dg;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles waiting for mem_rvalid_i before abort.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk_i  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have ports if_req_i in 1 fetch request; if_addr_i in 32 fetch address; if_gnt_o out 1 fetch accepted; if_rvalid_o out 1 fetch data valid; if_rdata_o out 32 fetch data.
REQ-006 SHALL have ports dm_req_i in 1; dm_we_i in 1; dm_addr_i in 32; dm_wdata_i in 32; dm_be_i in 4; dm_gnt_o out 1; dm_rvalid_o out 1 load data / store done; dm_rdata_o out 32.
REQ-007 SHALL have ports mem_req_o out 1; mem_we_o out 1; mem_addr_o out 32; mem_wdata_o out 32; mem_be_o out 4; mem_gnt_i in 1 request accepted; mem_rvalid_i in 1 response; mem_rdata_i in 32.
REQ-008 SHALL have ports flush_i in 1 (commit branch taken, kills in-flight fetch); error_o out 1 sticky timeout flag.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT_IF, WAIT_DM; one outstanding memory transaction at a time.
REQ-010 IDLE: if any request, SHALL drive mem_req_o=1 combinationally with winner's fields; if_req_i ignored while flush_i=1.
REQ-011 Grant SHALL occur when mem_req_o & mem_gnt_i: winner's gnt_o pulses same cycle; next state WAIT_IF or WAIT_DM; loser's gnt_o stays 0.
REQ-012 Fetch transactions SHALL drive mem_we_o=0, mem_be_o=4'b1111, mem_wdata_o=0.
REQ-013 WAIT_x: on mem_rvalid_i, SHALL pulse owner's rvalid_o for exactly that cycle with rdata_o=mem_rdata_i (combinational, zero latency); next state IDLE; no new request that cycle.
REQ-014 flush_i in WAIT_IF or in the cycle the fetch is granted SHALL set a drop flag; the matching response SHALL be consumed with if_rvalid_o=0; drop flag cleared on return to IDLE.
REQ-015 flush_i SHALL NOT affect WAIT_DM or data grants.
REQ-016 A wait counter SHALL count cycles in WAIT_x; on reaching TIMEOUT_CYCLES without mem_rvalid_i: error_o set (sticky until reset), no rvalid_o pulse, next state IDLE.
REQ-017 mem_rvalid_i in IDLE SHALL be ignored.
REQ-018 Requesters SHALL hold req/fields stable until gnt; arbiter SHALL NOT latch unaccepted requests.

Reset
REQ-019 On rst_i: state IDLE, drop flag 0, wait counter 0, error_o 0, last-winner = DM; all gnt/rvalid outputs 0, mem_req_o 0.
REQ-020 Reset mid-transaction SHALL abandon it; a later mem_rvalid_i SHALL be ignored per REQ-017.

Configuration
REQ-021 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous if_req_i & dm_req_i, grant the requester not granted last; last-winner updated on every grant.
REQ-022 Macro undefined: fixed priority, DM always wins contention; last-winner register absent.

Structure
REQ-023 tartaruga_pkg SHALL hold mem_arb_state_t (IDLE, WAIT_IF, WAIT_DM) and mem_owner_t (OWNER_IF, OWNER_DM).
REQ-024 One sub-module, mem_arb_pick: combinational winner select from the two requests and last-winner.

Verification
REQ-025 Single fetch 0x100, mem_gnt_i same cycle, rvalid 3 cycles later data 0x00000013 -> if_gnt_o 1 cycle, if_rvalid_o 1 cycle with 0x13.
REQ-026 Simultaneous fetch 0x200 and store 0x1000/0xDEADBEEF/be 4'hF -> DM granted first; fetch granted first IDLE cycle after store rvalid.
REQ-027 With MEM_ARB_ROUND_ROBIN_EN, both requesting continuously for 4 grants -> order IF, DM, IF, DM.
REQ-028 Fetch granted, flush_i 1 cycle later, rvalid with 0xFFFFFFFF -> if_rvalid_o stays 0; next fetch returns data normally.
REQ-029 Load granted, no rvalid for 16 cycles -> error_o=1 persisting, FSM IDLE, later request granted normally.
REQ-030 rst_i asserted in WAIT_DM, rvalid arrives after reset -> dm_rvalid_o 0, all outputs at reset values.
